// File: rtl/seq_shifter_if.sv
// Start/busy/done handshake and data bundle for seq_shifter.
// abort_i exists only when SEQ_SHIFTER_ABORT_EN is defined.
interface seq_shifter_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH) + 1
);
  logic             start_i;
  logic [WIDTH-1:0] din_i;
  logic [AMT_W-1:0] amt_i;
  logic [1:0]       mode_i;
`ifdef SEQ_SHIFTER_ABORT_EN
  logic             abort_i;
`endif
  logic             ready_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] dout_o;
  logic             carry_o;

  modport master (
    output start_i, din_i, amt_i, mode_i,
`ifdef SEQ_SHIFTER_ABORT_EN
    output abort_i,
`endif
    input  ready_o, busy_o, done_o, dout_o, carry_o
  );

  modport slave (
    input  start_i, din_i, amt_i, mode_i,
`ifdef SEQ_SHIFTER_ABORT_EN
    input  abort_i,
`endif
    output ready_o, busy_o, done_o, dout_o, carry_o
  );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: logical left/right, arithmetic right, rotate right, STEP bits per clock.
// Optional abort input enabled by defining SEQ_SHIFTER_ABORT_EN.
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  seq_shifter_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             carry_q, carry_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [1:0]       mode_q, mode_d;

  logic [AMT_W-1:0] eff_amt;
  logic [AMT_W-1:0] step_k;

  // Rotations wrap modulo WIDTH; plain shifts saturate at WIDTH.
  always_comb begin
    eff_amt = '0;
    if (bus.mode_i == 2'b11)
      eff_amt = bus.amt_i % AMT_W'(WIDTH);
    else if (bus.amt_i > AMT_W'(WIDTH))
      eff_amt = AMT_W'(WIDTH);
    else
      eff_amt = bus.amt_i;
  end

  assign step_k = (rem_q < AMT_W'(STEP)) ? rem_q : AMT_W'(STEP);

  // Chain of single-bit stages; stage gi is active only when gi < step_k,
  // so the carry out of the chain is the last bit to leave the register.
  logic [WIDTH-1:0] stage_val [STEP+1];
  logic             stage_cry [STEP+1];

  assign stage_val[0] = dout_q;
  assign stage_cry[0] = carry_q;

  generate
    for (genvar gi = 0; gi < STEP; gi++) begin : g_stage
      logic [WIDTH-1:0] one_val;
      logic             one_cry;

      always_comb begin
        one_val = stage_val[gi];
        one_cry = stage_cry[gi];
        case (mode_q)
          2'b00: begin
            one_val = {stage_val[gi][WIDTH-2:0], 1'b0};
            one_cry = stage_val[gi][WIDTH-1];
          end
          2'b01: begin
            one_val = {1'b0, stage_val[gi][WIDTH-1:1]};
            one_cry = stage_val[gi][0];
          end
          2'b10: begin
            one_val = {stage_val[gi][WIDTH-1], stage_val[gi][WIDTH-1:1]};
            one_cry = stage_val[gi][0];
          end
          2'b11: begin
            one_val = {stage_val[gi][0], stage_val[gi][WIDTH-1:1]};
            one_cry = stage_val[gi][0];
          end
        endcase
      end

      assign stage_val[gi+1] = (AMT_W'(gi) < step_k) ? one_val : stage_val[gi];
      assign stage_cry[gi+1] = (AMT_W'(gi) < step_k) ? one_cry : stage_cry[gi];
    end
  endgenerate

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      dout_q  <= '0;
      carry_q <= 1'b0;
      rem_q   <= '0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      carry_q <= carry_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    carry_d = carry_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          dout_d  = bus.din_i;
          carry_d = 1'b0;
          rem_d   = eff_amt;
          mode_d  = bus.mode_i;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
`ifdef SEQ_SHIFTER_ABORT_EN
        if (bus.abort_i) begin
          state_d = ST_IDLE;
        end else
`endif
        if (rem_q == '0) begin
          state_d = ST_DONE;
        end else begin
          dout_d  = stage_val[STEP];
          carry_d = stage_cry[STEP];
          rem_d   = rem_q - step_k;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ready_o = (state_q == ST_IDLE);
  assign bus.busy_o  = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign bus.done_o  = (state_q == ST_DONE);
  assign bus.dout_o  = dout_q;
  assign bus.carry_o = carry_q;
endmodule
